// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - wide-word to per-lane serializer feeding the write side of a sync FIFO
module fifo_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int FETCH_WIDTH = 6,
    parameter int CNT_WIDTH   = 3
) (
    input  logic                              wclk,
    input  logic                              wrst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              change_fetch_width,
    input  logic [CNT_WIDTH-1:0]              input_fetch_width,
    output logic [DATA_WIDTH-1:0]             fifo_din,
    output logic                              fifo_enq,
    input  logic                              fifo_full_n,
    output logic                              busy,
    output logic [15:0]                       elem_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0]   hold;
    logic [CNT_WIDTH-1:0]                idx;
    logic [CNT_WIDTH-1:0]                fw;
    logic [CNT_WIDTH-1:0]                word_fw;
    logic [CNT_WIDTH-1:0]                pend_val;
    logic                                pend;
    logic                                last;
    logic                                accept;
    logic                                width_ok;

    // Handshake and strobe decode; everything is forced quiet while reset is held
    always_comb begin
        busy     = wrst_n && (state == SEND);
        fifo_enq = busy && fifo_full_n;
        last     = fifo_enq && (idx == word_fw - CNT_WIDTH'(1));
        in_ready = wrst_n && !pend && ((state == IDLE) || last);
        accept   = in_valid && in_ready;
        width_ok = (input_fetch_width != '0) &&
                   (input_fetch_width <= CNT_WIDTH'(FETCH_WIDTH));
    end

    // Lane mux: idx only moves on an enqueue, so the element stays put during a stall
    always_comb begin
        fifo_din = '0;
        if (busy) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (idx == CNT_WIDTH'(i)) begin
                    fifo_din = hold[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next state: an accept on the last lane keeps SEND for a bubble-free next word
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (accept) state_nxt = SEND;
                     else if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word capture, lane walk and element counter
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            hold       <= '0;
            idx        <= '0;
            word_fw    <= CNT_WIDTH'(FETCH_WIDTH);
            elem_count <= '0;
        end else begin
            if (accept) begin
                hold    <= in_data;
                word_fw <= fw;
                idx     <= '0;
            end else if (fifo_enq) begin
                idx <= last ? '0 : idx + CNT_WIDTH'(1);
            end
            if (fifo_enq) begin
                elem_count <= elem_count + 16'(1);
            end
        end
    end

    // Width change: held pending until no word is mid-flight; a request landing on the
    // same edge as an apply stays pending so the latest request always wins
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            fw       <= CNT_WIDTH'(FETCH_WIDTH);
            pend     <= 1'b0;
            pend_val <= CNT_WIDTH'(FETCH_WIDTH);
        end else begin
            if (pend && ((state == IDLE) || last)) begin
                fw   <= pend_val;
                pend <= 1'b0;
            end
            if (change_fetch_width && width_ok) begin
                pend     <= 1'b1;
                pend_val <= input_fetch_width;
            end
        end
    end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Write-domain (wclk) producer stage that sits directly upstream of the SyncFIFO feeding the aggregator.
- Accepts one wide packed word of FETCH_WIDTH lanes via a valid/ready handshake.
- Emits the first N lanes one element per cycle into the FIFO via its sENQ/sFULL_N interface, lane 0 first.
- N is a runtime fetch width (1..FETCH_WIDTH), changed with the same change/width protocol the aggregator uses, so both ends can be kept consistent.

Parameters:
- DATA_WIDTH, 8: bits per element/lane.
- FETCH_WIDTH, 6: maximum lanes per input word.
- CNT_WIDTH, 3: width of input_fetch_width and the lane index; must satisfy 2^CNT_WIDTH > FETCH_WIDTH.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, synchronous, active-low, sampled on wclk.
- in_data  in  FETCH_WIDTH*DATA_WIDTH  packed word; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted on a wclk edge where in_valid && in_ready.
- change_fetch_width  in  1  one-cycle request to load input_fetch_width.
- input_fetch_width  in  CNT_WIDTH  requested lanes per word.
- fifo_din  out  DATA_WIDTH  element to the FIFO (sD_IN).
- fifo_enq  out  1  enqueue strobe (sENQ).
- fifo_full_n  in  1  FIFO not full (sFULL_N).
- busy  out  1  high in SEND.
- elem_count  out  16  total elements enqueued since reset; wraps modulo 2^16.

Behaviour:
- Registers:
  - state: IDLE or SEND.
  - hold: in_data copy.
  - idx: current lane.
  - fw: active width; reset value FETCH_WIDTH.
  - word_fw: width latched with the word.
  - pend / pend_val: pending width change.
  - elem_count.
- Reset (wrst_n=0 at an edge):
  - state=IDLE, idx=0, fw=FETCH_WIDTH, pend=0, elem_count=0, hold=0.
  - Outputs: in_ready=0 while reset is asserted, fifo_enq=0, fifo_din=0, busy=0.
  - Reset mid-word discards the held word; no further elements of it are emitted.
- Combinational outputs:
  - fifo_enq = (state==SEND) && fifo_full_n.
  - fifo_din = lane idx of hold. It is 0 in IDLE. Lane selection follows idx, which does not advance while fifo_full_n=0, so fifo_din stays stable during a stall.
  - last = fifo_enq && (idx == word_fw-1).
  - in_ready = wrst_n && !pend && ((state==IDLE) || last).
- Accept: on an edge with in_valid && in_ready:
  - hold <= in_data, word_fw <= fw, idx <= 0, state <= SEND.
  - When acceptance coincides with last, this gives back-to-back words with no bubble.
- SEND:
  - On each edge with fifo_enq, idx increments and elem_count increments.
  - On last with no acceptance, state <= IDLE and idx <= 0.
  - Steady-state latency is 1 element per wclk while fifo_full_n=1. The first element of a word appears the cycle after acceptance.
- Width change:
  - If change_fetch_width=1 at an edge and 1 <= input_fetch_width <= FETCH_WIDTH, then pend <= 1 and pend_val <= input_fetch_width.
  - Values 0 or > FETCH_WIDTH are ignored; pend and fw are unchanged.
  - A new valid request while pend=1 overwrites pend_val.
  - Pending change applies (fw <= pend_val, pend <= 0) on the first edge where state==IDLE, or last occurs. in_ready is 0 meanwhile, which costs one bubble.
  - A word in flight always completes with its latched word_fw.
  - A word accepted on the same edge as change_fetch_width uses the old fw.
- Boundaries:
  - fifo_full_n=0 holds idx, fifo_din and elem_count.
  - in_valid while busy and not last is not accepted; the upstream source must hold it.
  - With fw=1, every word is emitted in exactly 1 cycle, back-to-back.

Test Plan:
- Reset, fifo_full_n=1, in_data lanes 0..5 = 1,2,3,4,5,6 with in_valid=1 -> fifo_din 1,2,3,4,5,6 on 6 consecutive cycles; a second word (lanes 7..12) follows with no gap; elem_count=12.
- Width change: mid-word, pulse change_fetch_width with width 4 -> current word emits all 6 lanes; in_ready low 1 cycle; subsequent words emit lanes 0..3 only.
- Backpressure: fifo_full_n toggles pseudo-randomly at 50% -> the emitted sequence is unchanged and in order, fifo_enq never asserts while fifo_full_n=0, and fifo_din is stable during stalls.
- Invalid width: change_fetch_width with width 0, then with width 7 -> fw stays at its previous value (6), in_ready is never dropped, and output is unchanged.
- fw=1: width set to 1, words with lane0 = 10, 20, 30 -> fifo_din 10, 20, 30 on consecutive cycles; in_ready stays high.
- Reset mid-word: wrst_n=0 after lane 2 is emitted -> no lanes 3..5 appear, elem_count=0, fw=6; the next word starts at lane 0.
